// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - state and JK code definitions shared by the counter controller
package jk_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_code_e;

  // Only bits that actually change get a non-HOLD code, so each cell's inputs show the transition.
  function automatic jk_code_e jk_code(input logic cur, input logic nxt);
    if (cur == nxt) return HOLD;
    return nxt ? SET : RESET;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-high reset
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// rtl/jk_counter_ctrl.sv - modulo up/down counter built on a JK flip-flop bank with IDLE/RUN/DONE control
module jk_counter_ctrl
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] j_d, k_d;

  assign tc   = up_dn ? (q == MAX_VAL) : (q == '0);
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  assign step_val = up_dn ? ((q == MAX_VAL) ? '0 : q + WIDTH'(1))
                          : ((q == '0) ? MAX_VAL : q - WIDTH'(1));

  // Extra bit so MODULUS == 2**WIDTH never clamps a legal value.
  assign load_clamped = ({1'b0, load_val} >= (WIDTH + 1)'(MODULUS)) ? MAX_VAL : load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = q;
    j_d     = '0;
    k_d     = '0;
    if (load) begin
      cnt_d = load_clamped;
      if (stop && state_q == RUN) state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (oneshot && tc) state_d = DONE;
          else               cnt_d   = step_val;
        end
        DONE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = up_dn ? '0 : MAX_VAL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    for (int i = 0; i < WIDTH; i++) begin
      {j_d[i], k_d[i]} = jk_code(q[i], cnt_d[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_d[i]),
      .k   (k_d[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb/tb_jk_counter_ctrl.sv - directed and randomized checks of jk_counter_ctrl against a behavioural model
module tb_jk_counter_ctrl;

  localparam int W   = 4;
  localparam int MOD = 10;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         rst, start, stop, load, up_dn, oneshot;
  logic [W-1:0] load_val, q, qb;
  logic         tc, busy, done;

  int total = 0;
  int bad   = 0;
  int mq, ms;
  logic ud_r, os_r;

  always #5 clk = ~clk;

  jk_counter_ctrl #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .up_dn    (up_dn),
    .oneshot  (oneshot),
    .q        (q),
    .qb       (qb),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic s, input logic sp, input logic ld, input int lv,
                     input logic ud, input logic os);
    int nq, ns;
    logic [W-1:0] cur, applied;
    logic         tcm;
    @(negedge clk);
    start = s; stop = sp; load = ld; load_val = W'(lv); up_dn = ud; oneshot = os;
    #1;
    tcm = ud ? (mq == MOD - 1) : (mq == 0);
    chk("q", 32'(q), 32'(mq));
    chk("qb", 32'(qb), 32'((~mq) & (2**W - 1)));
    chk("busy", 32'(busy), 32'(ms == M_RUN));
    chk("done", 32'(done), 32'(ms == M_DONE));
    chk("tc", 32'(tc), 32'(tcm));
    nq = mq;
    ns = ms;
    if (ld) begin
      nq = (lv >= MOD) ? MOD - 1 : lv;
      if (sp && ms == M_RUN) ns = M_IDLE;
    end else if (sp) begin
      if (ms == M_RUN) ns = M_IDLE;
    end else if (ms == M_IDLE) begin
      if (s) ns = M_RUN;
    end else if (ms == M_RUN) begin
      if (os && tcm) ns = M_DONE;
      else           nq = ud ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
    end else if (s) begin
      ns = M_RUN;
      nq = ud ? 0 : MOD - 1;
    end
    cur = W'(mq);
    for (int i = 0; i < W; i++) begin
      case ({dut.j_d[i], dut.k_d[i]})
        2'b00:   applied[i] = cur[i];
        2'b01:   applied[i] = 1'b0;
        2'b10:   applied[i] = 1'b1;
        default: applied[i] = ~cur[i];
      endcase
    end
    chk("jk", 32'(applied), 32'(nq));
    @(posedge clk);
    #1;
    mq = nq;
    ms = ns;
  endtask

  task automatic async_reset(input logic ud);
    start = 1'b0; stop = 1'b0; load = 1'b0; up_dn = ud; oneshot = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_qb", 32'(qb), 32'(2**W - 1));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tc", 32'(tc), 32'(!ud));
    @(posedge clk);
    #1;
    chk("rst_hold_q", 32'(q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mq = 0;
    ms = M_IDLE;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    load_val = '0; up_dn = 1'b1; oneshot = 1'b0;
    mq = 0; ms = M_IDLE;
    async_reset(1'b1);

    cyc(1, 0, 0, 0, 1, 0);
    repeat (12) cyc(0, 0, 0, 0, 1, 0);
    chk("wrap_seq_end", 32'(q), 32'd2);

    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    chk("pre_reset_q", 32'(q), 32'd5);
    async_reset(1'b0);

    cyc(0, 0, 1, 7, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    chk("oneshot_hold_q", 32'(q), 32'd9);
    chk("oneshot_done", 32'(done), 32'd1);
    cyc(1, 0, 0, 0, 1, 1);
    chk("restart_q", 32'(q), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    cyc(0, 0, 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("down_wrap_q", 32'(q), 32'd8);

    cyc(0, 0, 1, 12, 0, 0);
    chk("load_clamp_q", 32'(q), 32'd9);
    cyc(1, 1, 1, 3, 1, 0);
    chk("load_stop_q", 32'(q), 32'd3);
    chk("load_stop_busy", 32'(busy), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);

    ud_r = 1'b1;
    os_r = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) < 15) ud_r = ~ud_r;
      if ($urandom_range(0, 99) < 5)  os_r = ~os_r;
      if ($urandom_range(0, 199) == 0) begin
        async_reset(ud_r);
      end else begin
        cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 8, int'($urandom_range(0, 15)), ud_r, os_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_counter_ctrl.md
JK_COUNTER_CTRL -- requirements
Module: jk_counter_ctrl

Interface
REQ-001: Parameter WIDTH, default 4, counter bit width.
REQ-002: Parameter MODULUS, default 10, count modulus; legal range 2..2^WIDTH.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: rst  input  1  reset; asynchronous, active-high.
REQ-005: start  input  1  level; begin or resume counting.
REQ-006: stop  input  1  level; halt counting and hold value.
REQ-007: load  input  1  level; load load_val into counter.
REQ-008: load_val  input  WIDTH  value for load.
REQ-009: up_dn  input  1  1 = count up, 0 = count down; sampled every cycle.
REQ-010: oneshot  input  1  1 = stop at terminal value, 0 = wrap and continue.
REQ-011: q  output  WIDTH  counter value, taken from the flip-flop bank.
REQ-012: qb  output  WIDTH  bitwise complement of q, from the flip-flop bank.
REQ-013: tc  output  1  terminal count: q == MODULUS-1 when up_dn=1, q == 0 when up_dn=0; combinational.
REQ-014: busy  output  1  high in RUN.
REQ-015: done  output  1  high in DONE.

Function
REQ-016: Counter storage SHALL be WIDTH JK flip-flops; the controller drives only per-bit J/K, using hold=00, reset=01, set=10, toggle=11 to reach the next value.
REQ-017: States SHALL be IDLE, RUN and DONE.
REQ-018: IDLE: q holds; start=1 -> RUN on the next edge; counting begins the edge after entry.
REQ-019: RUN: q advances by 1 (up) or retreats by 1 (down) on every edge.
REQ-020: RUN, oneshot=0: up wraps MODULUS-1 -> 0; down wraps 0 -> MODULUS-1; state remains RUN.
REQ-021: RUN, oneshot=1, tc=1: q holds at terminal value and state -> DONE on that edge.
REQ-022: RUN, stop=1: state -> IDLE and q holds; no increment on that edge.
REQ-023: DONE: q holds; start=1 -> q reloads 0 (up) or MODULUS-1 (down) and state -> RUN.
REQ-024: Priority on one edge: load > stop > start > count.
REQ-025: load=1 in any state: q <= load_val, state unchanged; load_val >= MODULUS loads MODULUS-1.
REQ-026: load with stop in RUN: q <= load_val and state -> IDLE.
REQ-027: up_dn change mid-RUN takes effect on the next edge; no lost or doubled step.
REQ-028: qb SHALL equal ~q in every cycle, including during reset.

Reset
REQ-029: rst=1 SHALL force q=0, qb=all ones and state=IDLE immediately, regardless of clk.
REQ-030: During reset, busy=0 and done=0; tc=1 if up_dn=0, else 0.
REQ-031: Reset mid-RUN or mid-DONE SHALL abort to IDLE with q=0; counting resumes only after a new start.
REQ-032: The first edge after rst deasserts SHALL obey normal IDLE rules.

Structure
REQ-033: Shared package jk_counter_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the JK code constants (HOLD, RESET, SET, TOGGLE).
REQ-034: Sub-module jk_cell (one JK flip-flop: clk, rst async active-high, j, k, q, qb) SHALL be instantiated WIDTH times; next-value and J/K computation stays in jk_counter_ctrl.

Verification (WIDTH=4, MODULUS=10)
REQ-035: Reset mid-count at q=5, asynchronous to clk -> q=0, qb=4'hF, busy=0 immediately.
REQ-036: start pulse, up_dn=1, oneshot=0, 12 edges -> q = 1..9, 0, 1, 2; tc high only when q=9.
REQ-037: up_dn=1, oneshot=1 from q=7 -> q = 8, 9, then hold 9, done=1; start -> q=0, busy=1.
REQ-038: up_dn=0 in RUN from q=1 -> q = 0, 9, 8; tc high when q=0.
REQ-039: load=1 with load_val=12 -> q=9; load, stop and start together in RUN with load_val=3 -> q=3, state IDLE.
REQ-040: At every cycle of all scenarios -> qb == ~q, and the J/K codes driven match the q transition per REQ-016.
